multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: fetch/decode/execute/memory/write-back sequencing with memory wait timeout.
// Optional build macro CTRL_TRAP_EN: unsupported instructions park the FSM in TRAP instead of retiring as NOPs.
module multicycle_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int ALU_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ir_we,
    output logic             reg_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic [ALU_W-1:0] alu_sel,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             timeout,
    output logic             illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_BRANCH = 4'd3,
        S_JUMP   = 4'd4,
        S_MEM    = 4'd5,
        S_WB     = 4'd6,
        S_TRAP   = 4'd7
    } state_t;

    typedef enum logic [3:0] {
        C_ADD, C_SUB, C_SLT, C_ADDI, C_XORI, C_LW, C_SW,
        C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_BAD
    } cls_t;

    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_XOR = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(3);

    state_t     state_reg;
    cls_t       cls_reg;
    cls_t       dec_cls;
    logic [7:0] wait_reg;
    logic       at_limit;

    assign at_limit = (wait_reg == 8'(WAIT_MAX));
    assign state    = state_reg;

    always_comb begin
        dec_cls = C_BAD;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20:   dec_cls = C_ADD;
                    6'h22:   dec_cls = C_SUB;
                    6'h2A:   dec_cls = C_SLT;
                    6'h08:   dec_cls = C_JR;
                    default: dec_cls = C_BAD;
                endcase
            end
            6'h08:   dec_cls = C_ADDI;
            6'h0E:   dec_cls = C_XORI;
            6'h23:   dec_cls = C_LW;
            6'h2B:   dec_cls = C_SW;
            6'h04:   dec_cls = C_BEQ;
            6'h05:   dec_cls = C_BNE;
            6'h02:   dec_cls = C_J;
            6'h03:   dec_cls = C_JAL;
            default: dec_cls = C_BAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
            wait_reg  <= '0;
            cls_reg   <= C_ADD;
        end else begin
            // Counter only survives inside FETCH and MEM; every other state leaves it cleared.
            wait_reg <= '0;
            case (state_reg)
                S_FETCH: begin
                    if (run && !at_limit) begin
                        if (mem_ready)
                            state_reg <= S_DECODE;
                        else
                            wait_reg <= wait_reg + 8'd1;
                    end
                end
                S_DECODE: begin
                    cls_reg <= dec_cls;
                    case (dec_cls)
                        C_BEQ, C_BNE:      state_reg <= S_BRANCH;
                        C_J, C_JAL, C_JR:  state_reg <= S_JUMP;
`ifdef CTRL_TRAP_EN
                        C_BAD:             state_reg <= S_TRAP;
`else
                        C_BAD:             state_reg <= S_FETCH;
`endif
                        default:           state_reg <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    if (cls_reg == C_LW || cls_reg == C_SW)
                        state_reg <= S_MEM;
                    else
                        state_reg <= S_WB;
                end
                S_MEM: begin
                    if (at_limit)
                        state_reg <= S_FETCH;
                    else if (mem_ready)
                        state_reg <= (cls_reg == C_LW) ? S_WB : S_FETCH;
                    else
                        wait_reg <= wait_reg + 8'd1;
                end
                S_TRAP:  state_reg <= S_TRAP;
                default: state_reg <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        alu_sel    = ALU_ADD;
        alu_src_b  = 2'd0;
        pc_src     = 2'd0;
        reg_dst    = 2'd0;
        wb_sel     = 2'd0;
        instr_done = 1'b0;
        timeout    = 1'b0;
        illegal    = 1'b0;
        if (rst_n) begin
            case (state_reg)
                S_FETCH: begin
                    if (run && at_limit) begin
                        timeout = 1'b1;
                    end else if (run) begin
                        mem_re    = 1'b1;
                        alu_src_b = 2'd1;
                        ir_we     = mem_ready;
                        pc_we     = mem_ready;
                    end
                end
                S_DECODE: begin
`ifndef CTRL_TRAP_EN
                    instr_done = (dec_cls == C_BAD);
`endif
                end
                S_EXEC: begin
                    case (cls_reg)
                        C_SUB:              alu_sel = ALU_SUB;
                        C_SLT:              alu_sel = ALU_SLT;
                        C_ADDI, C_LW, C_SW: alu_src_b = 2'd2;
                        C_XORI: begin
                            alu_sel   = ALU_XOR;
                            alu_src_b = 2'd3;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (at_limit) begin
                        timeout = 1'b1;
                    end else begin
                        mem_re     = (cls_reg == C_LW);
                        mem_we     = (cls_reg == C_SW);
                        instr_done = mem_ready && (cls_reg == C_SW);
                    end
                end
                S_WB: begin
                    reg_we     = 1'b1;
                    instr_done = 1'b1;
                    case (cls_reg)
                        C_ADD, C_SUB, C_SLT: reg_dst = 2'd1;
                        C_LW:                wb_sel  = 2'd1;
                        default: ;
                    endcase
                end
                S_BRANCH: begin
                    alu_sel    = ALU_SUB;
                    pc_src     = 2'd1;
                    pc_we      = ((cls_reg == C_BEQ) && zero) || ((cls_reg == C_BNE) && !zero);
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_we      = 1'b1;
                    pc_src     = (cls_reg == C_JR) ? 2'd3 : 2'd2;
                    instr_done = 1'b1;
                    if (cls_reg == C_JAL) begin
                        reg_we  = 1'b1;
                        reg_dst = 2'd2;
                        wb_sel  = 2'd2;
                    end
                end
                S_TRAP: begin
`ifdef CTRL_TRAP_EN
                    illegal = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle output records compared against an instruction-level model.
module tb_multicycle_ctrl;

    localparam int WAIT_MAX = 15;
    localparam int ALU_W    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, run, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic pc_we, ir_we, reg_we, mem_re, mem_we;
    logic [ALU_W-1:0] alu_sel;
    logic [1:0] alu_src_b, pc_src, reg_dst, wb_sel;
    logic [3:0] state;
    logic instr_done, timeout, illegal;

    multicycle_ctrl #(.WAIT_MAX(WAIT_MAX), .ALU_W(ALU_W)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we),
        .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we), .alu_sel(alu_sel),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .reg_dst(reg_dst), .wb_sel(wb_sel),
        .state(state), .instr_done(instr_done), .timeout(timeout), .illegal(illegal)
    );

    typedef struct packed {
        logic [3:0] st;
        logic pc_we, ir_we, reg_we, mem_re, mem_we;
        logic [2:0] alu;
        logic [1:0] srcb, pcs, rdst, wbs;
        logic done, tmo, ill;
    } out_t;

    out_t exp_q[$];
    logic rdy_q[$];
    out_t obs_q[$];
    int vectors = 0;
    int miscompares = 0;

    function automatic out_t sample();
        out_t r;
        r.st = state; r.pc_we = pc_we; r.ir_we = ir_we; r.reg_we = reg_we;
        r.mem_re = mem_re; r.mem_we = mem_we; r.alu = alu_sel; r.srcb = alu_src_b;
        r.pcs = pc_src; r.rdst = reg_dst; r.wbs = wb_sel;
        r.done = instr_done; r.tmo = timeout; r.ill = illegal;
        return r;
    endfunction

    // Instruction kinds: 0 add,1 sub,2 slt,3 addi,4 xori,5 lw,6 sw,7 beq,8 bne,9 j,10 jal,11 jr,12 unsupported
    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: return (fn == 6'h20) ? 0 : (fn == 6'h22) ? 1 : (fn == 6'h2A) ? 2 : (fn == 6'h08) ? 11 : 12;
            6'h08: return 3;
            6'h0E: return 4;
            6'h23: return 5;
            6'h2B: return 6;
            6'h04: return 7;
            6'h05: return 8;
            6'h02: return 9;
            6'h03: return 10;
            default: return 12;
        endcase
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction: fw fetch wait cycles, mw memory wait cycles
    // (mw >= WAIT_MAX means memory never answers before the timeout).
    task automatic build_model(input logic [5:0] op, input logic [5:0] fn, input logic z,
                               input int fw, input int mw);
        out_t r;
        int k;
        k = kind_of(op, fn);
        exp_q.delete();
        rdy_q.delete();
        for (int i = 0; i <= fw; i++) begin
            r = '0; r.mem_re = 1'b1; r.srcb = 2'd1;
            if (i == fw) begin r.ir_we = 1'b1; r.pc_we = 1'b1; end
            exp_q.push_back(r); rdy_q.push_back(i == fw);
        end
        r = '0; r.st = 4'd1;
        if (k == 12) begin
`ifdef CTRL_TRAP_EN
            exp_q.push_back(r); rdy_q.push_back(1'b0);
            for (int i = 0; i < 3; i++) begin
                r = '0; r.st = 4'd7; r.ill = 1'b1;
                exp_q.push_back(r); rdy_q.push_back(1'b1);
            end
`else
            r.done = 1'b1;
            exp_q.push_back(r); rdy_q.push_back(1'b0);
`endif
            return;
        end
        exp_q.push_back(r); rdy_q.push_back(1'b0);
        if (k <= 6) begin
            r = '0; r.st = 4'd2;
            r.alu  = (k == 1) ? 3'd1 : (k == 2) ? 3'd3 : (k == 4) ? 3'd2 : 3'd0;
            r.srcb = (k <= 2) ? 2'd0 : (k == 4) ? 2'd3 : 2'd2;
            exp_q.push_back(r); rdy_q.push_back(1'b0);
            if (k == 5 || k == 6) begin
                if (mw >= WAIT_MAX) begin
                    for (int j = 0; j < WAIT_MAX; j++) begin
                        r = '0; r.st = 4'd5; r.mem_re = (k == 5); r.mem_we = (k == 6);
                        exp_q.push_back(r); rdy_q.push_back(1'b0);
                    end
                    r = '0; r.st = 4'd5; r.tmo = 1'b1;
                    exp_q.push_back(r); rdy_q.push_back(1'b1);
                    return;
                end
                for (int j = 0; j <= mw; j++) begin
                    r = '0; r.st = 4'd5; r.mem_re = (k == 5); r.mem_we = (k == 6);
                    r.done = (k == 6) && (j == mw);
                    exp_q.push_back(r); rdy_q.push_back(j == mw);
                end
                if (k == 6) return;
            end
            r = '0; r.st = 4'd6; r.reg_we = 1'b1; r.done = 1'b1;
            r.rdst = (k <= 2) ? 2'd1 : 2'd0;
            r.wbs  = (k == 5) ? 2'd1 : 2'd0;
            exp_q.push_back(r); rdy_q.push_back(1'b0);
        end else if (k == 7 || k == 8) begin
            r = '0; r.st = 4'd3; r.alu = 3'd1; r.pcs = 2'd1; r.done = 1'b1;
            r.pc_we = (k == 7) ? z : !z;
            exp_q.push_back(r); rdy_q.push_back(1'b0);
        end else begin
            r = '0; r.st = 4'd4; r.pc_we = 1'b1; r.done = 1'b1;
            r.pcs = (k == 11) ? 2'd3 : 2'd2;
            if (k == 10) begin r.reg_we = 1'b1; r.rdst = 2'd2; r.wbs = 2'd2; end
            exp_q.push_back(r); rdy_q.push_back(1'b0);
        end
    endtask

    // Drives one instruction for as many cycles as the model expects and records the outputs.
    task automatic run_seq(input logic [5:0] op, input logic [5:0] fn, input logic z);
        obs_q.delete();
        for (int i = 0; i < exp_q.size(); i++) begin
            opcode = op; funct = fn; zero = z; run = 1'b1; mem_ready = rdy_q[i];
            @(negedge clk);
            obs_q.push_back(sample());
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        $display("instr op=%02h fn=%02h zero=%0b cycles=%0d", op, fn, z, exp_q.size());
    endtask

    task automatic test_reset();
        out_t r;
        rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            r = sample(); vectors++;
            if (r !== out_t'(0)) begin
                miscompares++; $display("FAIL reset cyc%0d got %h exp %h", i, r, out_t'(0));
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1; run = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_idle();
        out_t r;
        run = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            r = sample(); vectors++;
            if (r !== out_t'(0)) begin
                miscompares++; $display("FAIL idle cyc%0d got %h exp %h", i, r, out_t'(0));
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_add();
        build_model(6'h00, 6'h20, 1'b0, 0, 0);
        run_seq(6'h00, 6'h20, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL add cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        run = 1'b0;
        @(negedge clk); vectors++;
        if (state !== 4'd0 || instr_done !== 1'b0) begin
            miscompares++; $display("FAIL add_retire state %0d done %0b exp 0 0", state, instr_done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lw_wait();
        int re_cnt;
        build_model(6'h23, 6'h00, 1'b0, 0, 3);
        run_seq(6'h23, 6'h00, 1'b0);
        re_cnt = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i].st == 4'd5 && obs_q[i].mem_re) re_cnt++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL lw_wait cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (re_cnt != 4) begin
            miscompares++; $display("FAIL lw_mem_re_cycles got %0d exp 4", re_cnt);
        end
    endtask

    task automatic test_branch();
        build_model(6'h04, 6'h00, 1'b1, 0, 0);
        run_seq(6'h04, 6'h00, 1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL beq cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        build_model(6'h05, 6'h00, 1'b1, 1, 0);
        run_seq(6'h05, 6'h00, 1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL bne cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_jump();
        build_model(6'h03, 6'h00, 1'b0, 0, 0);
        run_seq(6'h03, 6'h00, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL jal cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        build_model(6'h00, 6'h08, 1'b0, 0, 0);
        run_seq(6'h00, 6'h08, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL jr cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    // Fetch never served: timeout on every (WAIT_MAX+1)th cycle, ready on that cycle is ignored.
    task automatic test_timeout();
        logic exp_tmo;
        run = 1'b1; opcode = 6'h00; funct = 6'h20;
        for (int c = 1; c <= 2 * (WAIT_MAX + 1); c++) begin
            exp_tmo = (c % (WAIT_MAX + 1)) == 0;
            mem_ready = exp_tmo;
            @(negedge clk); vectors++;
            if (timeout !== exp_tmo || mem_re !== !exp_tmo || ir_we !== 1'b0 || state !== 4'd0) begin
                miscompares++;
                $display("FAIL fetch_timeout cyc%0d tmo %0b re %0b ir %0b st %0d exp tmo %0b re %0b ir 0 st 0",
                         c, timeout, mem_re, ir_we, state, exp_tmo, !exp_tmo);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        $display("fetch timeout sequence cycles=%0d", 2 * (WAIT_MAX + 1));
    endtask

    task automatic test_random();
        logic [5:0] op, fn;
        logic z;
        int k, fw, mw;
        for (int n = 0; n < 40; n++) begin
`ifdef CTRL_TRAP_EN
            k = $urandom_range(0, 11);
`else
            k = $urandom_range(0, 12);
`endif
            fn = 6'($urandom_range(0, 63));
            case (k)
                0: begin op = 6'h00; fn = 6'h20; end
                1: begin op = 6'h00; fn = 6'h22; end
                2: begin op = 6'h00; fn = 6'h2A; end
                3: op = 6'h08;
                4: op = 6'h0E;
                5: op = 6'h23;
                6: op = 6'h2B;
                7: op = 6'h04;
                8: op = 6'h05;
                9: op = 6'h02;
                10: op = 6'h03;
                11: begin op = 6'h00; fn = 6'h08; end
                default: begin op = 6'h00; fn = 6'h21; end
            endcase
            z  = 1'($urandom_range(0, 1));
            fw = $urandom_range(0, 4);
            mw = ($urandom_range(0, 5) == 0) ? WAIT_MAX + $urandom_range(0, 2) : $urandom_range(0, 4);
            build_model(op, fn, z, fw, mw);
            run_seq(op, fn, z);
            for (int i = 0; i < exp_q.size(); i++) begin
                vectors++;
                if (obs_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL random n%0d op %02h cyc%0d got %h exp %h", n, op, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        build_model(6'h3F, 6'h00, 1'b0, 0, 0);
        run_seq(6'h3F, 6'h00, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL illegal cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        rst_n = 1'b0; run = 1'b1;
        @(negedge clk); @(posedge clk); #1;
        rst_n = 1'b1; run = 1'b0;
        @(negedge clk); vectors++;
        if (state !== 4'd0 || illegal !== 1'b0) begin
            miscompares++; $display("FAIL illegal_reset state %0d ill %0b exp 0 0", state, illegal);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_sw();
        run = 1'b1; opcode = 6'h2B; funct = 6'h00; zero = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk); vectors++;
        if (state !== 4'd5 || mem_we !== 1'b1) begin
            miscompares++; $display("FAIL sw_in_mem state %0d we %0b exp 5 1", state, mem_we);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (state !== 4'd0 || mem_we !== 1'b0 || mem_re !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_sw state %0d we %0b re %0b exp 0 0 0", state, mem_we, mem_re);
        end
        rst_n = 1'b1;
        $display("reset during sw memory phase");
        build_model(6'h0E, 6'h00, 1'b0, 2, 0);
        run_seq(6'h0E, 6'h00, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL post_reset_xori cyc%0d got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        opcode = 6'h00; funct = 6'h00;
        @(posedge clk); #1;
        test_reset();
        test_idle();
        test_add();
        test_lw_wait();
        test_branch();
        test_jump();
        test_timeout();
        test_random();
        test_illegal();
        test_reset_mid_sw();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
